// File: rtl/memory_bus_arbiter_if.sv
// Request/response signal bundle between the two requesters, the arbiter and memory.
// The slave modport is the arbiter's view. The master modport is the view of the
// surrounding requesters and memory.
interface memory_bus_arbiter_if;
   logic [31:0] inst_addr;
   logic        inst_read_enable;
   logic        inst_wait_req;
   logic        inst_valid;
   logic [31:0] inst_data;

   logic [31:0] bus_address;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_byte_enable;
   logic        bus_read_enable;
   logic        bus_write_enable;
   logic        bus_wait_req;
   logic        bus_valid;
   logic [31:0] bus_read_data;

   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_byte_enable;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic        mem_wait_req;
   logic        mem_valid;
   logic [31:0] mem_read_data;
   logic        protocol_error;

   modport slave (
      input  inst_addr, inst_read_enable,
      input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
      input  mem_wait_req, mem_valid, mem_read_data,
      output inst_wait_req, inst_valid, inst_data,
      output bus_wait_req, bus_valid, bus_read_data,
      output mem_address, mem_write_data, mem_byte_enable, mem_read_enable, mem_write_enable,
      output protocol_error
   );

   modport master (
      output inst_addr, inst_read_enable,
      output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
      output mem_wait_req, mem_valid, mem_read_data,
      input  inst_wait_req, inst_valid, inst_data,
      input  bus_wait_req, bus_valid, bus_read_data,
      input  mem_address, mem_write_data, mem_byte_enable, mem_read_enable, mem_write_enable,
      input  protocol_error
   );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one memory port.
// Requests are forwarded with zero latency. A stalled owner is held until accepted.
// Read responses are routed back in order using a tag FIFO.
module memory_bus_arbiter #(
   parameter int unsigned PENDING_DEPTH = 4
) (
   input  logic                clock,
   input  logic                reset,
   memory_bus_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(PENDING_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic        TAG_INST = 1'b0;
   localparam logic        TAG_DATA = 1'b1;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      ST_FREE      = 2'd0,
      ST_LOCK_INST = 2'd1,
      ST_LOCK_DATA = 2'd2
   } state_e;

   state_e             state_q;
   state_e             state_d;
   owner_e             owner_c;
   owner_e             arb_c;

   logic               last_data_q;
   logic               perr_q;
   logic               tag_mem [PENDING_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;

   logic               full_c;
   logic               empty_c;
   logic               inst_ok_c;
   logic               data_ok_c;
   logic               fwd_read_c;
   logic               accept_c;
   logic               push_c;
   logic               pop_c;
   logic               stray_c;

   // Eligibility uses the registered count, so a same-cycle pop never unblocks a read.
   assign full_c    = (count_q == CNT_W'(PENDING_DEPTH));
   assign empty_c   = (count_q == '0);
   assign inst_ok_c = bus.inst_read_enable & ~full_c;
   assign data_ok_c = bus.bus_write_enable | (bus.bus_read_enable & ~full_c);

   // Round-robin between eligible requesters: the side not granted last wins a tie.
   always_comb begin
      arb_c = OWN_NONE;
      if (inst_ok_c && data_ok_c) begin
         arb_c = last_data_q ? OWN_INST : OWN_DATA;
      end else if (inst_ok_c) begin
         arb_c = OWN_INST;
      end else if (data_ok_c) begin
         arb_c = OWN_DATA;
      end
   end

   // State register: the lock remembers which side is stalled on the memory port.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_FREE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: lock on a forwarded request that the memory stalls.
   always_comb begin
      state_d = ST_FREE;
      if (!bus.mem_wait_req) begin
         state_d = ST_FREE;
      end else if (owner_c == OWN_INST) begin
         state_d = ST_LOCK_INST;
      end else if (owner_c == OWN_DATA) begin
         state_d = ST_LOCK_DATA;
      end
   end

   // Output logic: owner selection, forwarding, handshakes and response routing.
   always_comb begin
      owner_c              = OWN_NONE;
      fwd_read_c           = 1'b0;
      bus.mem_address      = '0;
      bus.mem_write_data   = '0;
      bus.mem_byte_enable  = '0;
      bus.mem_read_enable  = 1'b0;
      bus.mem_write_enable = 1'b0;
      bus.inst_wait_req    = 1'b1;
      bus.bus_wait_req     = 1'b1;
      bus.inst_valid       = 1'b0;
      bus.bus_valid        = 1'b0;
      bus.inst_data        = '0;
      bus.bus_read_data    = '0;
      bus.protocol_error   = 1'b0;

      if (!reset) begin
         // A locked owner that has withdrawn its request releases the port to arbitration.
         unique case (state_q)
            ST_LOCK_INST: owner_c = inst_ok_c ? OWN_INST : arb_c;
            ST_LOCK_DATA: owner_c = data_ok_c ? OWN_DATA : arb_c;
            default:      owner_c = arb_c;
         endcase

         unique case (owner_c)
            OWN_INST: begin
               fwd_read_c          = 1'b1;
               bus.mem_address     = bus.inst_addr;
               bus.mem_byte_enable = 4'b1111;
               bus.inst_wait_req   = bus.mem_wait_req;
            end
            OWN_DATA: begin
               fwd_read_c           = bus.bus_read_enable & ~full_c;
               bus.mem_address      = bus.bus_address;
               bus.mem_write_data   = bus.bus_write_data;
               bus.mem_byte_enable  = bus.bus_byte_enable;
               bus.mem_write_enable = bus.bus_write_enable;
               bus.bus_wait_req     = bus.mem_wait_req;
            end
            default: ;
         endcase
         bus.mem_read_enable = fwd_read_c;

         bus.inst_valid     = pop_c & (tag_mem[rd_ptr_q] == TAG_INST);
         bus.bus_valid      = pop_c & (tag_mem[rd_ptr_q] == TAG_DATA);
         bus.inst_data      = bus.mem_read_data;
         bus.bus_read_data  = bus.mem_read_data;
         bus.protocol_error = perr_q;
      end
   end

   assign accept_c = (owner_c != OWN_NONE) & ~bus.mem_wait_req;
   assign push_c   = accept_c & fwd_read_c;
   assign pop_c    = bus.mem_valid & ~empty_c;
   assign stray_c  = bus.mem_valid & empty_c;

   // Tag storage needs no reset: entries are only read while counted as occupied.
   always_ff @(posedge clock) begin
      if (push_c && !reset) begin
         tag_mem[wr_ptr_q] <= (owner_c == OWN_DATA) ? TAG_DATA : TAG_INST;
      end
   end

   // FIFO pointers, occupancy, round-robin history and the sticky error flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         last_data_q <= 1'b1;
         perr_q      <= 1'b0;
      end else begin
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         unique case ({push_c, pop_c})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (accept_c) begin
            last_data_q <= (owner_c == OWN_DATA);
         end
         if (stray_c) begin
            perr_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed and random checks of memory_bus_arbiter.
// The reference model is built from a pending-tag queue and simple arbitration rules.
module tb_memory_bus_arbiter;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   memory_bus_arbiter_if bus_if ();

   memory_bus_arbiter #(.PENDING_DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clock = ~clock;

   // Model state
   bit   q_tags[$];
   bit   last_data_m;
   int   lock_m;
   bit   perr_m;
   int   exp_owner;
   bit   exp_accept;

   // Observed values from the most recent cycle, kept for directed constant checks
   logic [31:0] o_addr, o_idata, o_bdata;
   logic        o_re, o_we, o_iw, o_bw, o_iv, o_bv, o_pe;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic ireq, input logic [31:0] iaddr,
                      input logic bre, input logic bwe, input logic [31:0] baddr,
                      input logic [31:0] bwd, input logic [3:0] bbe,
                      input logic mwait, input logic mvalid, input logic [31:0] mrdata);
      bit          full, i_ok, d_ok, stray;
      int          own;
      logic [31:0] e_addr, e_wd, e_data;
      logic [3:0]  e_be;
      logic        e_re, e_we, e_iw, e_bw, e_iv, e_bv, e_pe;

      @(negedge clock);
      reset                   = rst;
      bus_if.inst_read_enable = ireq;
      bus_if.inst_addr        = iaddr;
      bus_if.bus_read_enable  = bre;
      bus_if.bus_write_enable = bwe;
      bus_if.bus_address      = baddr;
      bus_if.bus_write_data   = bwd;
      bus_if.bus_byte_enable  = bbe;
      bus_if.mem_wait_req     = mwait;
      bus_if.mem_valid        = mvalid;
      bus_if.mem_read_data    = mrdata;
      #1;

      // Owner: 0 none, 1 inst, 2 data
      full = (q_tags.size() >= DEPTH);
      i_ok = ireq && !full;
      d_ok = bwe || (bre && !full);
      if (rst)                        own = 0;
      else if (lock_m == 1 && i_ok)   own = 1;
      else if (lock_m == 2 && d_ok)   own = 2;
      else if (i_ok && d_ok)          own = last_data_m ? 1 : 2;
      else if (i_ok)                  own = 1;
      else if (d_ok)                  own = 2;
      else                            own = 0;
      exp_owner  = own;
      exp_accept = (own != 0) && !mwait;

      e_addr = (own == 1) ? iaddr : (own == 2) ? baddr : 32'h0;
      e_wd   = (own == 2) ? bwd : 32'h0;
      e_be   = (own == 1) ? 4'hF : (own == 2) ? bbe : 4'h0;
      e_re   = (own == 1) || (own == 2 && bre && !full);
      e_we   = (own == 2) && bwe;
      e_iw   = !(own == 1 && !mwait);
      e_bw   = !(own == 2 && !mwait);
      e_iv   = !rst && mvalid && q_tags.size() > 0 && q_tags[0] == 1'b0;
      e_bv   = !rst && mvalid && q_tags.size() > 0 && q_tags[0] == 1'b1;
      e_data = rst ? 32'h0 : mrdata;
      e_pe   = !rst && perr_m;

      chk("mem_address",      bus_if.mem_address, e_addr);
      chk("mem_write_data",   bus_if.mem_write_data, e_wd);
      chk("mem_byte_enable",  32'(bus_if.mem_byte_enable), 32'(e_be));
      chk("mem_read_enable",  32'(bus_if.mem_read_enable), 32'(e_re));
      chk("mem_write_enable", 32'(bus_if.mem_write_enable), 32'(e_we));
      chk("inst_wait_req",    32'(bus_if.inst_wait_req), 32'(e_iw));
      chk("bus_wait_req",     32'(bus_if.bus_wait_req), 32'(e_bw));
      chk("inst_valid",       32'(bus_if.inst_valid), 32'(e_iv));
      chk("bus_valid",        32'(bus_if.bus_valid), 32'(e_bv));
      chk("inst_data",        bus_if.inst_data, e_data);
      chk("bus_read_data",    bus_if.bus_read_data, e_data);
      chk("protocol_error",   32'(bus_if.protocol_error), 32'(e_pe));

      o_addr  = bus_if.mem_address;
      o_idata = bus_if.inst_data;
      o_bdata = bus_if.bus_read_data;
      o_re    = bus_if.mem_read_enable;
      o_we    = bus_if.mem_write_enable;
      o_iw    = bus_if.inst_wait_req;
      o_bw    = bus_if.bus_wait_req;
      o_iv    = bus_if.inst_valid;
      o_bv    = bus_if.bus_valid;
      o_pe    = bus_if.protocol_error;

      @(posedge clock);
      if (rst) begin
         q_tags.delete();
         last_data_m = 1'b1;
         lock_m      = 0;
         perr_m      = 1'b0;
      end else begin
         stray = mvalid && q_tags.size() == 0;
         if (mvalid && q_tags.size() > 0) void'(q_tags.pop_front());
         if (stray) perr_m = 1'b1;
         if (exp_accept && e_re) q_tags.push_back(own == 2);
         if (exp_accept) last_data_m = (own == 2);
         lock_m = (own != 0 && mwait) ? own : 0;
      end
   endtask

   task automatic idle(input logic mvalid, input logic [31:0] mrdata);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, mvalid, mrdata);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      bit          i_pend, d_pend, d_w, rs, mw, mv;
      logic [31:0] i_a, d_a, d_wd;
      logic [3:0]  d_be;

      reset = 1'b1;
      bus_if.inst_addr = '0; bus_if.inst_read_enable = 1'b0;
      bus_if.bus_address = '0; bus_if.bus_write_data = '0; bus_if.bus_byte_enable = '0;
      bus_if.bus_read_enable = 1'b0; bus_if.bus_write_enable = 1'b0;
      bus_if.mem_wait_req = 1'b0; bus_if.mem_valid = 1'b0; bus_if.mem_read_data = '0;
      last_data_m = 1'b1; lock_m = 0; perr_m = 1'b0;

      // Outputs held quiet during reset
      do_reset();
      chk("rst_inst_wait", 32'(o_iw), 32'd1);
      chk("rst_bus_wait",  32'(o_bw), 32'd1);
      do_reset();

      // Tie right after reset goes to the instruction side first
      cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
      chk("tie_c0_addr", o_addr, 32'h100);
      chk("tie_c0_iw",   32'(o_iw), 32'd0);
      chk("tie_c0_bw",   32'(o_bw), 32'd1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
      chk("tie_c1_addr", o_addr, 32'h2000);

      // Stalled store keeps the port while a fetch waits
      do_reset();
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 32'hDEAD, 4'hF, 1'b1, 1'b0, 32'h0);
      chk("lock_c0_addr", o_addr, 32'h3000);
      for (int k = 1; k <= 3; k++) begin
         cyc(1'b0, 1'b1, 32'h4000, 1'b0, 1'b1, 32'h3000, 32'hDEAD, 4'hF, (k < 3), 1'b0, 32'h0);
         chk("lock_addr", o_addr, 32'h3000);
         chk("lock_iw",   32'(o_iw), 32'd1);
      end
      cyc(1'b0, 1'b1, 32'h4000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      chk("lock_after_addr", o_addr, 32'h4000);
      chk("lock_after_iw",   32'(o_iw), 32'd0);

      // In-order response routing
      do_reset();
      cyc(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      idle(1'b1, 32'hA);
      chk("route_a_iv", 32'(o_iv), 32'd1);
      chk("route_a_data", o_idata, 32'hA);
      idle(1'b1, 32'hB);
      chk("route_b_bv", 32'(o_bv), 32'd1);
      chk("route_b_iv", 32'(o_iv), 32'd0);
      chk("route_b_data", o_bdata, 32'hB);
      idle(1'b1, 32'hC);
      chk("route_c_iv", 32'(o_iv), 32'd1);
      chk("route_c_data", o_idata, 32'hC);

      // Full tag FIFO holds reads, but a store still passes
      do_reset();
      for (int k = 0; k < DEPTH; k++)
         cyc(1'b0, 1'b1, 32'h100 + 32'(k), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 32'h600, 32'h55, 4'h3, 1'b0, 1'b0, 32'h0);
      chk("full_re",   32'(o_re), 32'd0);
      chk("full_we",   32'(o_we), 32'd1);
      chk("full_addr", o_addr, 32'h600);
      chk("full_iw",   32'(o_iw), 32'd1);
      cyc(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h77);
      chk("full_pop_re", 32'(o_re), 32'd0);
      chk("full_pop_iv", 32'(o_iv), 32'd1);
      cyc(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      chk("full_next_re",   32'(o_re), 32'd1);
      chk("full_next_addr", o_addr, 32'h500);

      // Stray response is dropped and flagged until reset
      do_reset();
      idle(1'b1, 32'h99);
      chk("stray_iv", 32'(o_iv), 32'd0);
      chk("stray_bv", 32'(o_bv), 32'd0);
      idle(1'b0, 32'h0);
      chk("stray_pe1", 32'(o_pe), 32'd1);
      idle(1'b0, 32'h0);
      chk("stray_pe2", 32'(o_pe), 32'd1);
      do_reset();
      idle(1'b0, 32'h0);
      chk("stray_pe_cleared", 32'(o_pe), 32'd0);

      // Reset with reads outstanding
      cyc(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
      chk("mid_rst_tie_addr", o_addr, 32'h30);
      chk("mid_rst_pe", 32'(o_pe), 32'd0);
      idle(1'b1, 32'h5);
      chk("mid_rst_resp_iv", 32'(o_iv), 32'd1);
      idle(1'b1, 32'h6);
      chk("mid_rst_no_stale", 32'(o_bv), 32'd0);

      // Random traffic from requesters that hold each request until it is accepted
      do_reset();
      i_pend = 0; d_pend = 0; d_w = 0;
      i_a = '0; d_a = '0; d_wd = '0; d_be = '0;
      for (int n = 0; n < 2000; n++) begin
         if (!i_pend && $urandom_range(0, 2) == 0) begin
            i_pend = 1; i_a = $urandom;
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1; d_w = 1'($urandom_range(0, 1));
            d_a = $urandom; d_wd = $urandom; d_be = 4'($urandom);
         end
         mw = ($urandom_range(0, 3) == 0);
         mv = (q_tags.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
         rs = ($urandom_range(0, 99) == 0);
         cyc(rs, i_pend, i_a, d_pend && !d_w, d_pend && d_w, d_a,
             d_w ? d_wd : 32'h0, d_w ? d_be : 4'h0, mw, mv, $urandom);
         if (rs) begin
            i_pend = 0; d_pend = 0;
         end else begin
            if (exp_accept && exp_owner == 1) i_pend = 0;
            if (exp_accept && exp_owner == 2) d_pend = 0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
